// File: rtl/rpn_stack_engine.sv
// RPN calculator core: a DEPTH x WIDTH operand stack with push/pop/add/multiply driven by button releases.
// Multiplication is a WIDTH-cycle shift-add sequence. busy stays high until its result is written back.
//
//  state | meaning
//  IDLE  | waiting for a button-release event; push/pop/add/trivial mult complete here
//  MUL   | shift-add multiply, one multiplier bit per cycle
//  WB    | write product back to the stack, drop one entry
module rpn_stack_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_push,
    input  logic             btn_pop,
    input  logic             btn_add,
    input  logic             btn_mult,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_en,
    output logic [CNT_W-1:0] size,
    output logic [DEPTH-1:0] size_leds,
    output logic             stk_ovf,
    output logic             arith_ovf,
    output logic             busy
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       stack    [DEPTH];
    logic [WIDTH-1:0]       stack_nx [DEPTH];
    logic [CNT_W-1:0]       size_nx;
    logic                   stk_ovf_nx, arith_ovf_nx;
    logic [3:0]             prev, btn, rel;
    logic [2*WIDTH-1:0]     acc, acc_nx, mcand, mcand_nx;
    logic [WIDTH-1:0]       mplier, mplier_nx;
    logic [BC_W-1:0]        bit_cnt, bit_cnt_nx;
    logic [WIDTH:0]         sum;

    assign btn = {btn_mult, btn_add, btn_pop, btn_push};
    assign rel = prev & ~btn;
    assign sum = {1'b0, stack[0]} + {1'b0, stack[1]};

    always_comb begin
        state_nx     = state;
        stack_nx     = stack;
        size_nx      = size;
        stk_ovf_nx   = stk_ovf;
        arith_ovf_nx = arith_ovf;
        acc_nx       = acc;
        mcand_nx     = mcand;
        mplier_nx    = mplier;
        bit_cnt_nx   = bit_cnt;
        case (state)
            IDLE: begin
                // Fixed priority push > pop > add > mult; losers of the cycle are dropped.
                if (rel[0]) begin
                    if (size == CNT_W'(DEPTH)) begin
                        stk_ovf_nx   = 1'b1;
                        arith_ovf_nx = 1'b1;
                    end else begin
                        for (int i = DEPTH - 1; i > 0; i--) stack_nx[i] = stack[i-1];
                        stack_nx[0]  = din;
                        size_nx      = size + CNT_W'(1);
                        stk_ovf_nx   = 1'b0;
                        arith_ovf_nx = 1'b0;
                    end
                end else if (rel[1]) begin
                    if (size == '0) begin
                        stk_ovf_nx   = 1'b1;
                        arith_ovf_nx = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH - 1; i++) stack_nx[i] = stack[i+1];
                        stack_nx[DEPTH-1] = '0;
                        size_nx      = size - CNT_W'(1);
                        stk_ovf_nx   = 1'b0;
                        arith_ovf_nx = 1'b0;
                    end
                end else if (rel[2]) begin
                    arith_ovf_nx = 1'b0;
                    if (size >= CNT_W'(2)) begin
                        stack_nx[0] = sum[WIDTH-1:0];
                        for (int i = 1; i < DEPTH - 1; i++) stack_nx[i] = stack[i+1];
                        stack_nx[DEPTH-1] = '0;
                        size_nx      = size - CNT_W'(1);
                        stk_ovf_nx   = 1'b0;
                        arith_ovf_nx = sum[WIDTH];
                    end
                end else if (rel[3]) begin
                    if (size == CNT_W'(1)) begin
                        stack_nx[0]  = '0;
                        arith_ovf_nx = 1'b0;
                    end else if (size >= CNT_W'(2)) begin
                        mcand_nx   = {{WIDTH{1'b0}}, stack[0]};
                        mplier_nx  = stack[1];
                        acc_nx     = '0;
                        bit_cnt_nx = BC_W'(WIDTH - 1);
                        state_nx   = MUL;
                    end
                end
            end
            MUL: begin
                if (mplier[0]) acc_nx = acc + mcand;
                mcand_nx   = mcand << 1;
                mplier_nx  = mplier >> 1;
                bit_cnt_nx = bit_cnt - BC_W'(1);
                if (bit_cnt == '0) state_nx = WB;
            end
            WB: begin
                stack_nx[0] = acc[WIDTH-1:0];
                for (int i = 1; i < DEPTH - 1; i++) stack_nx[i] = stack[i+1];
                stack_nx[DEPTH-1] = '0;
                size_nx      = size - CNT_W'(1);
                stk_ovf_nx   = 1'b0;
                arith_ovf_nx = |acc[2*WIDTH-1:WIDTH];
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            size      <= '0;
            stk_ovf   <= 1'b0;
            arith_ovf <= 1'b0;
            prev      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nx;
            for (int i = 0; i < DEPTH; i++) stack[i] <= stack_nx[i];
            size      <= size_nx;
            stk_ovf   <= stk_ovf_nx;
            arith_ovf <= arith_ovf_nx;
            prev      <= btn;
            acc       <= acc_nx;
            mcand     <= mcand_nx;
            mplier    <= mplier_nx;
            bit_cnt   <= bit_cnt_nx;
        end
    end

    assign busy    = (state != IDLE);
    assign dout_en = (size != '0);
    assign dout    = dout_en ? stack[0] : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_leds
        assign size_leds[i] = (size > CNT_W'(i));
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Bench for rpn_stack_engine: directed vector table, hand-written multi-cycle sequences,
// and random button traffic compared against a queue-based calculator model.
module tb_rpn_stack_engine;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          btn_push = 1'b0, btn_pop = 1'b0, btn_add = 1'b0, btn_mult = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          dout_en;
    logic [CW-1:0] size;
    logic [D-1:0]  size_leds;
    logic          stk_ovf, arith_ovf, busy;

    rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_push(btn_push), .btn_pop(btn_pop), .btn_add(btn_add), .btn_mult(btn_mult),
        .din(din), .dout(dout), .dout_en(dout_en), .size(size), .size_leds(size_leds),
        .stk_ovf(stk_ovf), .arith_ovf(arith_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: q[0] is the top of stack.
    logic [W-1:0] q[$];
    logic         m_stk, m_ar;

    typedef struct {
        logic [3:0]   m;      // {mult, add, pop, push}
        logic [W-1:0] d;
        logic [W-1:0] e_dout;
        int           e_size;
        logic         e_stk;
        logic         e_ar;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_mult, btn_add, btn_pop, btn_push} = m;
    endtask

    task automatic press(input logic [3:0] m, input logic [W-1:0] d);
        int n;
        @(negedge clk);
        din = d;
        set_btns(m);
        @(negedge clk);
        set_btns(4'b0);
        @(negedge clk);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        set_btns(4'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        q.delete();
        m_stk = 1'b0;
        m_ar  = 1'b0;
    endtask

    task automatic model_op(input logic [3:0] m, input logic [W-1:0] d);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        if (m[0]) begin
            if (q.size() == D) begin m_stk = 1'b1; m_ar = 1'b1; end
            else begin q.push_front(d); m_stk = 1'b0; m_ar = 1'b0; end
        end else if (m[1]) begin
            if (q.size() == 0) begin m_stk = 1'b1; m_ar = 1'b1; end
            else begin void'(q.pop_front()); m_stk = 1'b0; m_ar = 1'b0; end
        end else if (m[2]) begin
            m_ar = 1'b0;
            if (q.size() >= 2) begin
                s = {1'b0, q[0]} + {1'b0, q[1]};
                void'(q.pop_front());
                void'(q.pop_front());
                q.push_front(s[W-1:0]);
                m_stk = 1'b0;
                m_ar  = s[W];
            end
        end else if (m[3]) begin
            if (q.size() == 1) begin
                q[0] = '0;
                m_ar = 1'b0;
            end else if (q.size() >= 2) begin
                p = {{W{1'b0}}, q[0]} * {{W{1'b0}}, q[1]};
                void'(q.pop_front());
                void'(q.pop_front());
                q.push_front(p[W-1:0]);
                m_stk = 1'b0;
                m_ar  = |p[2*W-1:W];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] e_dout;
        e_dout = (q.size() != 0) ? q[0] : '0;
        chk({tag, "_dout"},  32'(dout),      32'(e_dout));
        chk({tag, "_size"},  32'(size),      32'(q.size()));
        chk({tag, "_stk"},   32'(stk_ovf),   32'(m_stk));
        chk({tag, "_ar"},    32'(arith_ovf), 32'(m_ar));
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"},    32'(dout),      32'd0);
        chk({tag, "_dout_en"}, 32'(dout_en),   32'd0);
        chk({tag, "_size"},    32'(size),      32'd0);
        chk({tag, "_leds"},    32'(size_leds), 32'd0);
        chk({tag, "_stk"},     32'(stk_ovf),   32'd0);
        chk({tag, "_ar"},      32'(arith_ovf), 32'd0);
        chk({tag, "_busy"},    32'(busy),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] m;
        logic [W-1:0] d;

        tbl[0]  = '{4'b0001, 8'h05, 8'h05, 1, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 8'h03, 8'h03, 2, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 8'h00, 8'h05, 1, 1'b0, 1'b0};
        tbl[3]  = '{4'b0010, 8'h00, 8'h00, 0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0010, 8'h00, 8'h00, 0, 1'b1, 1'b1};
        tbl[5]  = '{4'b1000, 8'h00, 8'h00, 0, 1'b1, 1'b1};
        tbl[6]  = '{4'b0001, 8'hF0, 8'hF0, 1, 1'b0, 1'b0};
        tbl[7]  = '{4'b0001, 8'h20, 8'h20, 2, 1'b0, 1'b0};
        tbl[8]  = '{4'b0100, 8'h00, 8'h10, 1, 1'b0, 1'b1};
        tbl[9]  = '{4'b0100, 8'h00, 8'h10, 1, 1'b0, 1'b0};
        tbl[10] = '{4'b1000, 8'h00, 8'h00, 1, 1'b0, 1'b0};
        tbl[11] = '{4'b0010, 8'h00, 8'h00, 0, 1'b0, 1'b0};
        tbl[12] = '{4'b0001, 8'h01, 8'h01, 1, 1'b0, 1'b0};
        tbl[13] = '{4'b0001, 8'h01, 8'h01, 2, 1'b0, 1'b0};
        tbl[14] = '{4'b0001, 8'h01, 8'h01, 3, 1'b0, 1'b0};
        tbl[15] = '{4'b0001, 8'h01, 8'h01, 4, 1'b0, 1'b0};
        tbl[16] = '{4'b0001, 8'h07, 8'h01, 4, 1'b1, 1'b1};
        tbl[17] = '{4'b0010, 8'h00, 8'h01, 3, 1'b0, 1'b0};
        tbl[18] = '{4'b0100, 8'h00, 8'h02, 2, 1'b0, 1'b0};
        tbl[19] = '{4'b0101, 8'h33, 8'h33, 3, 1'b0, 1'b0};
        tbl[20] = '{4'b1010, 8'h00, 8'h02, 2, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            press(tbl[i].m, tbl[i].d);
            chk($sformatf("vec%0d_dout", i),    32'(dout),      32'(tbl[i].e_dout));
            chk($sformatf("vec%0d_size", i),    32'(size),      32'(tbl[i].e_size));
            chk($sformatf("vec%0d_leds", i),    32'(size_leds), (32'd1 << tbl[i].e_size) - 32'd1);
            chk($sformatf("vec%0d_dout_en", i), 32'(dout_en),   32'(tbl[i].e_size != 0));
            chk($sformatf("vec%0d_stk", i),     32'(stk_ovf),   32'(tbl[i].e_stk));
            chk($sformatf("vec%0d_ar", i),      32'(arith_ovf), 32'(tbl[i].e_ar));
        end

        // 0x0C * 0x0A with a pop pressed and released while busy.
        do_reset();
        press(4'b0001, 8'h0A);
        press(4'b0001, 8'h0C);
        @(negedge clk);
        btn_mult = 1'b1;
        @(negedge clk);
        btn_mult = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 3) btn_pop = 1'b1;
            if (n == 4) chk("mult_no_early_write", 32'(dout), 32'h0C);
            if (n == 5) btn_pop = 1'b0;
            @(negedge clk);
        end
        btn_pop = 1'b0;
        chk("mult_busy_cycles", 32'(n), 32'd9);
        chk("mult_dout", 32'(dout), 32'h78);
        chk("mult_size", 32'(size), 32'd1);
        chk("mult_ar", 32'(arith_ovf), 32'd0);
        chk("mult_stk", 32'(stk_ovf), 32'd0);
        repeat (3) @(negedge clk);
        chk("pop_during_busy_ignored", 32'(size), 32'd1);

        // 0x20 * 0x10 overflows into the upper half.
        press(4'b0001, 8'h10);
        press(4'b0001, 8'h20);
        press(4'b1000, 8'h00);
        chk("mult_ovf_dout", 32'(dout), 32'h00);
        chk("mult_ovf_ar", 32'(arith_ovf), 32'd1);
        chk("mult_ovf_size", 32'(size), 32'd2);
        press(4'b0010, 8'h00);
        chk("mult_ovf_below", 32'(dout), 32'h78);

        // Reset asserted in the middle of a multiply.
        do_reset();
        press(4'b0001, 8'h03);
        press(4'b0001, 8'h04);
        @(negedge clk);
        btn_mult = 1'b1;
        @(negedge clk);
        btn_mult = 1'b0;
        repeat (4) @(negedge clk);
        chk("midmul_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("midmul_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk_zero("midmul_after");

        // Random traffic against the model, mostly single buttons with some coincident releases.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0) m = 4'b0001 << $urandom_range(0, 3);
            else m = 4'($urandom_range(1, 15));
            d = W'($urandom_range(0, 255));
            press(m, d);
            model_op(m, d);
            check_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
